// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: hold/flush of IF/ID, ID/EX, EX/MEM, MEM/WB, PC enable,
// MDU sequencing and a saturating stall-cycle counter. Optional macro: HAZARD_FORWARD_EN.
module hz_hit (
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  output logic       hit_o
);
  assign hit_o = (rd_i != 5'd0) &
                 ((use_rs1_i & (rs1_i == rd_i)) | (use_rs2_i & (rs2_i == rd_i)));
endmodule

module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int MW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [MW-1:0] LAT_M1 = MW'(MDU_LAT - 1);

  typedef enum logic {RUN, MDU} state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic ex_hit, mem_hit;
  logic mem_stall, mdu_stall, data_hz;
  logic pw_c, ifh_c, iff_c, idh_c, idf_c, exh_c, exf_c, wbf_c, done_c;

  hz_hit u_ex_hit (
    .rd_i(ex_rd), .rs1_i(id_rs1), .rs2_i(id_rs2),
    .use_rs1_i(id_use_rs1), .use_rs2_i(id_use_rs2), .hit_o(ex_hit)
  );
  hz_hit u_mem_hit (
    .rd_i(mem_rd), .rs1_i(id_rs1), .rs2_i(id_rs2),
    .use_rs1_i(id_use_rs1), .use_rs2_i(id_use_rs2), .hit_o(mem_hit)
  );

  assign mem_stall = dmem_req & ~dmem_ready;
  assign mdu_stall = ((state_q == RUN) & ex_mdu_start) |
                     ((state_q == MDU) & (mdu_cnt_q != '0));

`ifdef HAZARD_FORWARD_EN
  // Forwarding covers ALU results; only a load in EX still has to wait.
  assign data_hz = ex_mem_read & ex_hit;
  logic unused_nofwd;
  assign unused_nofwd = ex_reg_write ^ mem_reg_write ^ mem_hit;
`else
  assign data_hz = (ex_reg_write & ex_hit) | (mem_reg_write & mem_hit);
  logic unused_fwd;
  assign unused_fwd = ex_mem_read;
`endif

  always_comb begin
    pw_c   = 1'b1;
    ifh_c  = 1'b0;
    iff_c  = 1'b0;
    idh_c  = 1'b0;
    idf_c  = 1'b0;
    exh_c  = 1'b0;
    exf_c  = 1'b0;
    wbf_c  = 1'b0;
    done_c = (state_q == MDU) & (mdu_cnt_q == '0) & ~mem_stall;
    if (mem_stall) begin
      pw_c  = 1'b0;
      ifh_c = 1'b1;
      idh_c = 1'b1;
      exh_c = 1'b1;
      wbf_c = 1'b1;
    end else if (mdu_stall) begin
      pw_c  = 1'b0;
      ifh_c = 1'b1;
      idh_c = 1'b1;
      exf_c = 1'b1;
    end else if (ex_branch_taken) begin
      // Squashing the younger instruction also resolves any dependency it had.
      iff_c = 1'b1;
      idf_c = 1'b1;
    end else if (data_hz) begin
      pw_c  = 1'b0;
      ifh_c = 1'b1;
      idf_c = 1'b1;
    end
  end

  // Everything is forced low while reset is asserted, including pc_write.
  assign pc_write     = rst_n & pw_c;
  assign if_id_hold   = rst_n & ifh_c;
  assign if_id_flush  = rst_n & iff_c;
  assign id_ex_hold   = rst_n & idh_c;
  assign id_ex_flush  = rst_n & idf_c;
  assign ex_mem_hold  = rst_n & exh_c;
  assign ex_mem_flush = rst_n & exf_c;
  assign mem_wb_flush = rst_n & wbf_c;
  assign mdu_done     = rst_n & done_c;
  assign stall_cnt    = stall_cnt_q;

  always_comb begin
    state_d   = state_q;
    mdu_cnt_d = mdu_cnt_q;
    if (!mem_stall) begin
      case (state_q)
        RUN: if (ex_mdu_start) begin
          state_d   = MDU;
          mdu_cnt_d = LAT_M1;
        end
        MDU: if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - 1'b1;
             else                 state_d   = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (!pc_write && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_LAT=4, CNT_W=4 so saturation is reachable).
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_write, ex_mem_read, mem_reg_write;
  logic ex_branch_taken, ex_mdu_start, dmem_req, dmem_ready;
  logic pc_write, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
  logic ex_mem_hold, ex_mem_flush, mem_wb_flush, mdu_done;
  logic [3:0] stall_cnt;
  int n_cmp = 0;
  int n_err = 0;
  int exp_sc = 0;
  int nofwd_stall;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush),
    .ex_mem_hold(ex_mem_hold), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .mdu_done(mdu_done), .stall_cnt(stall_cnt)
  );

  // {pc_write, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
  //  ex_mem_hold, ex_mem_flush, mem_wb_flush, mdu_done}
  logic [8:0] ctrl;
  assign ctrl = {pc_write, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                 ex_mem_hold, ex_mem_flush, mem_wb_flush, mdu_done};

  localparam logic [8:0] C_ZERO = 9'b000000000;
  localparam logic [8:0] C_IDLE = 9'b100000000;
  localparam logic [8:0] C_LU   = 9'b010010000;
  localparam logic [8:0] C_BR   = 9'b101010000;
  localparam logic [8:0] C_MDU  = 9'b010100100;
  localparam logic [8:0] C_DONE = 9'b100000001;
  localparam logic [8:0] C_MEM  = 9'b010101010;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0;
    ex_branch_taken = 0; ex_mdu_start = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic load_use(input logic [4:0] rd);
    clr();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = rd; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  initial begin
`ifdef HAZARD_FORWARD_EN
    nofwd_stall = 0;
`else
    nofwd_stall = 1;
`endif
    clr();
    rst_n = 0;
    #1;
    chk("reset_ctrl", ctrl, C_ZERO);
    chk("reset_cnt", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1; #1;
    chk("idle", ctrl, C_IDLE);

    // Load-use, then the consumer moves on.
    @(negedge clk); load_use(5); #1;
    chk("load_use", ctrl, C_LU); exp_sc++;
    @(negedge clk); clr(); #1;
    chk("after_lu", ctrl, C_IDLE);
    chk("cnt_lu", stall_cnt, exp_sc);

    @(negedge clk); load_use(0); #1;
    chk("x0_no_stall", ctrl, C_IDLE);

    @(negedge clk); load_use(5); ex_branch_taken = 1; #1;
    chk("branch_over_hz", ctrl, C_BR);

    // Dependency on the MEM-stage writer: stalls only without forwarding.
    @(negedge clk); clr(); mem_reg_write = 1; mem_rd = 7; id_rs2 = 7; id_use_rs2 = 1; #1;
    chk("mem_dep", ctrl, nofwd_stall ? C_LU : C_IDLE); exp_sc += nofwd_stall;
    @(negedge clk); clr(); mem_reg_write = 1; mem_rd = 7; id_rs2 = 7; id_use_rs2 = 0; #1;
    chk("mem_dep_unused", ctrl, C_IDLE);
    @(negedge clk); clr(); ex_reg_write = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1; #1;
    chk("ex_alu_dep", ctrl, nofwd_stall ? C_LU : C_IDLE); exp_sc += nofwd_stall;
    @(negedge clk); clr(); #1;
    chk("cnt_deps", stall_cnt, exp_sc);

    // MDU op: four stall cycles, then done.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); ex_mdu_start = 1; #1;
      chk($sformatf("mdu_stall%0d", k), ctrl, C_MDU); exp_sc++;
    end
    @(negedge clk); #1;
    chk("mdu_done", ctrl, C_DONE);
    @(negedge clk); clr(); #1;
    chk("mdu_back_run", ctrl, C_IDLE);
    chk("cnt_mdu", stall_cnt, exp_sc);

    // MDU with a 3-cycle memory wait while mdu_cnt=2.
    @(negedge clk); ex_mdu_start = 1; #1;
    chk("mm_run", ctrl, C_MDU);
    @(negedge clk); #1;
    chk("mm_cnt3", ctrl, C_MDU);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); dmem_req = 1; dmem_ready = 0; #1;
      chk($sformatf("mm_memwait%0d", k), ctrl, C_MEM);
    end
    @(negedge clk); dmem_ready = 1; #1;
    chk("mm_cnt2", ctrl, C_MDU);
    @(negedge clk); dmem_req = 0; #1;
    chk("mm_cnt1", ctrl, C_MDU);
    @(negedge clk); #1;
    chk("mm_done", ctrl, C_DONE);
    @(negedge clk); clr(); #1;
    exp_sc += 7;
    chk("cnt_memwait", stall_cnt, exp_sc);

    // Reset in the middle of an MDU op (mdu_cnt=2).
    @(negedge clk); ex_mdu_start = 1;
    @(negedge clk);
    @(negedge clk); rst_n = 0; #1;
    chk("rst_mid_ctrl", ctrl, C_ZERO);
    chk("rst_mid_cnt", stall_cnt, 0);
    @(negedge clk); clr(); rst_n = 1; #1;
    chk("rst_release", ctrl, C_IDLE);

    // Saturation of the 4-bit counter.
    @(negedge clk); load_use(5);
    repeat (18) @(negedge clk);
    #1;
    chk("cnt_sat", stall_cnt, 15);
    @(negedge clk); clr(); #1;
    chk("cnt_sat_hold", stall_cnt, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline control unit for the 5-stage core.
- Watches register dependencies, taken branches, the multi-cycle MDU and data-memory handshakes.
- Drives hold (keep value) and flush (zero/bubble) controls of the four pipeline registers, plus the PC write enable.
- Contains a RUN/MDU state machine, an MDU latency counter and a saturating stall-cycle counter.

Parameters:
- MDU_LAT, 4, stall cycles inserted per MDU op; legal range ≥1.
- CNT_W, 16, width of stall_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  ID source reg 1.
- id_rs2  in  5  ID source reg 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  EX destination reg.
- ex_reg_write  in  1  EX writes rd.
- ex_mem_read  in  1  EX is a load.
- mem_rd  in  5  MEM destination reg.
- mem_reg_write  in  1  MEM writes rd.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- ex_mdu_start  in  1  EX holds a mul/div op (level, held while op in EX).
- dmem_req  in  1  MEM stage access valid.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC update enable.
- if_id_hold  out  1  hold IF/ID.
- if_id_flush  out  1  zero IF/ID.
- id_ex_hold  out  1  hold ID/EX.
- id_ex_flush  out  1  zero ID/EX (bubble).
- ex_mem_hold  out  1  hold EX/MEM.
- ex_mem_flush  out  1  zero EX/MEM.
- mem_wb_flush  out  1  zero MEM/WB.
- mdu_done  out  1  MDU result valid; EX may advance.
- stall_cnt  out  CNT_W  cycles with pc_write=0 after reset.

Behaviour:

Reset and output timing
- Reset: async on rst_n low. state=RUN, mdu_cnt=0, stall_cnt=0.
- While rst_n=0, all control outputs are 0 (including pc_write) and mdu_done=0.
- All control outputs are combinational from registered state plus current inputs; zero added latency.

Hazard terms
- mem_stall = dmem_req & ~dmem_ready.
- mdu_stall = (state==RUN & ex_mdu_start) | (state==MDU & mdu_cnt!=0).
- mdu_done = 1 when state==MDU & mdu_cnt==0 & ~mem_stall.
- hit(rd) = (rd!=0) & ((id_use_rs1 & id_rs1==rd) | (id_use_rs2 & id_rs2==rd)).
- data_hz = ex_mem_read & hit(ex_rd). Register x0 never causes a hazard.

Priority (first match wins; unlisted outputs are 0, pc_write defaults to 1)
1. mem_stall: pc_write=0; if_id_hold=1; id_ex_hold=1; ex_mem_hold=1; mem_wb_flush=1.
2. mdu_stall: pc_write=0; if_id_hold=1; id_ex_hold=1; ex_mem_flush=1.
3. ex_branch_taken: if_id_flush=1; id_ex_flush=1; pc_write=1. The dependent younger instruction is squashed, so a coincident data_hz is ignored.
4. data_hz: pc_write=0; if_id_hold=1; id_ex_flush=1.

FSM
- RUN → MDU when ex_mdu_start & ~mem_stall; load mdu_cnt = MDU_LAT-1.
- MDU: when ~mem_stall and mdu_cnt!=0, decrement. When mdu_cnt==0 and ~mem_stall, return to RUN and pulse mdu_done.
- mem_stall freezes the FSM and mdu_cnt.
- Total stall per MDU op = exactly MDU_LAT cycles when no memory stalls occur.
- MDU_LAT=1: MDU entered with mdu_cnt=0; done on the next cycle.
- ex_mdu_start and ex_branch_taken together never occur (same EX slot). If they do, mdu_stall wins.

stall_cnt
- Increments on each clock edge where rst_n=1 and pc_write==0.
- Saturates at all-ones; never wraps.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: the datapath has EX/MEM→EX forwarding. Only load-use (data_hz as above) stalls.
- Undefined: no forwarding. data_hz = (ex_reg_write & hit(ex_rd)) | (mem_reg_write & hit(mem_rd)); same response as priority 4. A load in EX still counts via ex_reg_write.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_write=0, if_id_hold=1, id_ex_flush=1 for one cycle. Same with ex_rd=0 → no stall.
- Branch + hazard: load-use case above with ex_branch_taken=1 → if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_hold=0.
- MDU, MDU_LAT=4: ex_mdu_start held → pc_write=0 for exactly 4 cycles, ex_mem_flush=1 in each; mdu_done=1 on the 5th cycle; state back to RUN.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles mid-MDU → all holds=1, mem_wb_flush=1, mdu_cnt frozen; MDU stall extends by 3; stall_cnt increases by 7 total.
- Reset mid-MDU: rst_n low at mdu_cnt=2 → outputs immediately 0, state=RUN, stall_cnt=0. Release with no inputs asserted → pc_write=1.
- No-forward build (HAZARD_FORWARD_EN undefined): mem_reg_write=1, mem_rd=7, id_rs2=7, id_use_rs2=1 → stall. With the macro defined → no stall.
